nap_scheduler: RTL and testbench

- Sequences the alarm sound/light block for a power-nap timer.
- Accepts user buttons and counts down the nap on a 1 Hz tick enable.
- At expiry, fires the alarm's start input; stops it on user stop, snooze or ring timeout.
- Sits between the debounced button/tick front end and the alarm block, owning its start/stop inputs.

---
 rtl/nap_pkg.sv | 18 +
 rtl/sec_downcounter.sv | 43 ++++
 rtl/nap_scheduler.sv | 141 ++++++++++++++
 tb/tb_nap_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// Shared types and default constants for the power-nap alarm scheduler.
package nap_pkg;

    // Scheduler states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } nap_state_e;

    localparam int unsigned NAP_SEC_DEF          = 1200;
    localparam int unsigned SNOOZE_SEC_DEF       = 300;
    localparam int unsigned RING_TIMEOUT_SEC_DEF = 60;
    localparam int unsigned MAX_SNOOZE_DEF       = 3;
    localparam int unsigned CNT_W_DEF            = 11;

endpackage

// File: rtl/sec_downcounter.sv
// Loadable seconds down-counter advanced by the 1 Hz tick enable.
// Clear wins over load, load wins over tick; a count of zero never decrements.
module sec_downcounter #(
    parameter int unsigned W = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_one
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, reload or one-second decrement.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_one = (count_q == W'(1));

endmodule

// File: rtl/nap_scheduler.sv
// Power-nap scheduler: counts the nap down on the 1 Hz tick, rings the alarm
// at expiry and handles stop, snooze, cancel and ring timeout.
module nap_scheduler
    import nap_pkg::*;
#(
    parameter int unsigned NAP_SEC          = NAP_SEC_DEF,
    parameter int unsigned SNOOZE_SEC       = SNOOZE_SEC_DEF,
    parameter int unsigned RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
    parameter int unsigned MAX_SNOOZE       = MAX_SNOOZE_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             start_btn,
    input  logic             cancel_btn,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic             alarm_start,
    output logic             alarm_stop,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       snooze_cnt,
    output logic             missed
);

    localparam logic [1:0] MAX_SN = 2'(MAX_SNOOZE);

    nap_state_e       state_q, state_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             missed_q, missed_d;
    logic             alarm_start_q, alarm_start_d;
    logic             alarm_stop_q, alarm_stop_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_tick;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_at_one;

    // One counter serves nap, snooze and ring time; it is reloaded on every state entry.
    sec_downcounter #(.W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tick     (cnt_tick),
        .clr      (cnt_clr),
        .count    (cnt_count),
        .at_one   (cnt_at_one)
    );

    // Next-state logic; in RINGING any acted-on or rejected button swallows a coincident tick.
    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        missed_d     = missed_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_tick     = 1'b0;
        cnt_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_btn) begin
                    state_d      = ST_COUNTING;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(NAP_SEC);
                    snooze_cnt_d = 2'd0;
                    missed_d     = 1'b0;
                end
            end
            ST_COUNTING, ST_SNOOZE: begin
                if (cancel_btn) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (tick) begin
                    if (cnt_at_one) begin
                        state_d      = ST_RINGING;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(RING_TIMEOUT_SEC);
                    end else begin
                        cnt_tick = 1'b1;
                    end
                end
            end
            ST_RINGING: begin
                if (stop_btn) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (snooze_btn) begin
                    if (snooze_cnt_q < MAX_SN) begin
                        state_d      = ST_SNOOZE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(SNOOZE_SEC);
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                    end
                end else if (tick) begin
                    if (cnt_at_one) begin
                        state_d  = ST_IDLE;
                        missed_d = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_tick = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        alarm_start_d = (state_d == ST_RINGING) && (state_q != ST_RINGING);
        alarm_stop_d  = (state_d != ST_RINGING);
    end

    // Registered state and alarm controls; the alarm is held stopped in reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            snooze_cnt_q  <= 2'd0;
            missed_q      <= 1'b0;
            alarm_start_q <= 1'b0;
            alarm_stop_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            snooze_cnt_q  <= snooze_cnt_d;
            missed_q      <= missed_d;
            alarm_start_q <= alarm_start_d;
            alarm_stop_q  <= alarm_stop_d;
        end
    end

    assign state_o     = state_q;
    assign remaining   = cnt_count;
    assign snooze_cnt  = snooze_cnt_q;
    assign missed      = missed_q;
    assign alarm_start = alarm_start_q;
    assign alarm_stop  = alarm_stop_q;

endmodule

// File: tb/tb_nap_scheduler.sv
// Directed bench for nap_scheduler with short nap/snooze/ring lengths.
module tb_nap_scheduler;

    localparam int unsigned CW = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          cancel_btn = 1'b0;
    logic          snooze_btn = 1'b0;
    logic          stop_btn = 1'b0;
    logic          alarm_start;
    logic          alarm_stop;
    logic [1:0]    state_o;
    logic [CW-1:0] remaining;
    logic [1:0]    snooze_cnt;
    logic          missed;

    int tests_run = 0;
    int tests_failed = 0;

    nap_scheduler #(
        .NAP_SEC          (5),
        .SNOOZE_SEC       (3),
        .RING_TIMEOUT_SEC (4),
        .MAX_SNOOZE       (2),
        .CNT_W            (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .start_btn   (start_btn),
        .cancel_btn  (cancel_btn),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .alarm_start (alarm_start),
        .alarm_stop  (alarm_stop),
        .state_o     (state_o),
        .remaining   (remaining),
        .snooze_cnt  (snooze_cnt),
        .missed      (missed)
    );

    always #5 clock = ~clock;

    // inp = {start, cancel, snooze, stop, tick}
    typedef struct {
        logic [4:0]    inp;
        logic [1:0]    st;
        logic [CW-1:0] rem;
        logic [1:0]    sc;
        logic          mis;
        logic          ast;
        logic          asp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] inp, input logic [1:0] st, input int rem,
                       input logic [1:0] sc, input logic mis, input logic ast, input logic asp);
        vec_t v;
        v.inp = inp; v.st = st; v.rem = CW'(rem); v.sc = sc;
        v.mis = mis; v.ast = ast; v.asp = asp;
        vq.push_back(v);
    endtask

    // n ticks in a counting state starting from remaining == from
    task automatic add_ticks(input int from, input int n, input logic [1:0] st, input logic [1:0] sc);
        for (int i = 0; i < n; i++) add(5'b00001, st, from - i, sc, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input logic [1:0] st, input int rem,
                         input logic [1:0] sc, input logic mis, input logic ast, input logic asp);
        logic [17:0] got, exp;
        got = {state_o, remaining, snooze_cnt, missed, alarm_start, alarm_stop};
        exp = {st, CW'(rem), sc, mis, ast, asp};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got st=%0d rem=%0d sc=%0d missed=%0b astart=%0b astop=%0b, expected st=%0d rem=%0d sc=%0d missed=%0b astart=%0b astop=%0b",
                     name, state_o, remaining, snooze_cnt, missed, alarm_start, alarm_stop,
                     st, rem, sc, mis, ast, asp);
        end
    endtask

    task automatic drive(input logic [4:0] inp);
        {start_btn, cancel_btn, snooze_btn, stop_btn, tick} = inp;
        @(posedge clock);
        #1;
        {start_btn, cancel_btn, snooze_btn, stop_btn, tick} = 5'b0;
    endtask

    initial begin
        // Start-ignores-tick, start ignored while counting, snooze limit, timeout
        add(5'b10001, 1, 5, 0, 0, 0, 1);
        add(5'b00001, 1, 4, 0, 0, 0, 1);
        add(5'b10000, 1, 4, 0, 0, 0, 1);
        add_ticks(3, 3, 1, 0);
        add(5'b00001, 2, 4, 0, 0, 1, 0);
        add(5'b00000, 2, 4, 0, 0, 0, 0);
        add(5'b00001, 2, 3, 0, 0, 0, 0);
        add(5'b00100, 3, 3, 1, 0, 0, 1);
        add_ticks(2, 2, 3, 1);
        add(5'b00001, 2, 4, 1, 0, 1, 0);
        add(5'b00100, 3, 3, 2, 0, 0, 1);
        add_ticks(2, 2, 3, 2);
        add(5'b00001, 2, 4, 2, 0, 1, 0);
        add(5'b00100, 2, 4, 2, 0, 0, 0);
        add(5'b00001, 2, 3, 2, 0, 0, 0);
        add(5'b00001, 2, 2, 2, 0, 0, 0);
        add(5'b00001, 2, 1, 2, 0, 0, 0);
        add(5'b00001, 0, 0, 2, 1, 0, 1);
        add(5'b00011, 0, 0, 2, 1, 0, 1);
        add(5'b10000, 1, 5, 0, 0, 0, 1);
        // Basic nap answered with stop
        add_ticks(4, 4, 1, 0);
        add(5'b00001, 2, 4, 0, 0, 1, 0);
        add(5'b00010, 0, 0, 0, 0, 0, 1);
        // Cancel beats the expiring tick
        add(5'b10000, 1, 5, 0, 0, 0, 1);
        add_ticks(4, 4, 1, 0);
        add(5'b01001, 0, 0, 0, 0, 0, 1);
        add(5'b00000, 0, 0, 0, 0, 0, 1);
        // Stop beats snooze
        add(5'b10000, 1, 5, 0, 0, 0, 1);
        add_ticks(4, 4, 1, 0);
        add(5'b00001, 2, 4, 0, 0, 1, 0);
        add(5'b00110, 0, 0, 0, 0, 0, 1);
        // Cancel during snooze
        add(5'b10000, 1, 5, 0, 0, 0, 1);
        add_ticks(4, 4, 1, 0);
        add(5'b00001, 2, 4, 0, 0, 1, 0);
        add(5'b00100, 3, 3, 1, 0, 0, 1);
        add(5'b01000, 0, 0, 1, 0, 0, 1);

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 0, 0, 0, 0, 0, 1);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].inp);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].rem, vq[i].sc,
                  vq[i].mis, vq[i].ast, vq[i].asp);
        end

        // Asynchronous reset while ringing, then start held across a reset edge
        drive(5'b10000);
        for (int i = 0; i < 5; i++) drive(5'b00001);
        check("ring_before_reset", 2, 4, 0, 0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_mid_cycle", 0, 0, 0, 0, 0, 1);
        start_btn = 1'b1;
        @(posedge clock);
        #1;
        check("start_during_reset", 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        start_btn = 1'b0;
        @(posedge clock);
        #1;
        check("after_reset_release", 0, 0, 0, 0, 0, 1);
        drive(5'b10000);
        check("start_after_reset", 1, 5, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
